// File: rtl/led_scan.sv
// Row-scanned LED panel driver: fetch a 64-pixel row, shift it out
// serially, latch it, then light it for DISPLAY_CYCLES clocks.
module led_scan #(
  parameter int DISPLAY_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        frame_row_rd,
  output logic [5:0]  frame_row_addr,
  input  logic [63:0] frame_row_data,
  output logic        panel_data,
  output logic        panel_sclk,
  output logic        panel_latch,
  output logic        panel_oe_n,
  output logic [5:0]  panel_row,
  output logic        frame_done
);

  localparam logic [15:0] DISP_LAST = 16'(DISPLAY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SHIFT, LATCH, DISPLAY
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic        phase_q, phase_d;
  logic [15:0] disp_q, disp_d;
  logic [63:0] sr_q, sr_d;

  logic        rd_q, rd_d;
  logic [5:0]  addr_q, addr_d;
  logic        data_q, data_d;
  logic        sclk_q, sclk_d;
  logic        latch_q, latch_d;
  logic        oe_n_q, oe_n_d;
  logic [5:0]  prow_q, prow_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    phase_d = phase_q;
    disp_d  = disp_q;
    sr_d    = sr_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    sclk_d  = 1'b0;
    latch_d = 1'b0;
    oe_n_d  = 1'b1;
    prow_d  = prow_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          row_d   = '0;
          rd_d    = 1'b1;
          addr_d  = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        state_d = SHIFT;
        sr_d    = frame_row_data;
        col_d   = '0;
        phase_d = 1'b0;
        data_d  = frame_row_data[0];
      end
      SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else if (col_q == 6'd63) begin
          state_d = LATCH;
          latch_d = 1'b1;
          prow_d  = row_q;
        end else begin
          col_d   = col_q + 6'd1;
          phase_d = 1'b0;
          data_d  = sr_q[col_d];
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        disp_d  = '0;
        oe_n_d  = 1'b0;
      end
      DISPLAY: begin
        if (disp_q != DISP_LAST) begin
          disp_d = disp_q + 16'd1;
          oe_n_d = 1'b0;
        end else if (row_q != 6'd63) begin
          row_d   = row_q + 6'd1;
          state_d = FETCH;
          rd_d    = 1'b1;
          addr_d  = row_d;
        end else begin
          // frame boundary: the only place besides IDLE where enable counts
          done_d = 1'b1;
          row_d  = '0;
          if (enable) begin
            state_d = FETCH;
            rd_d    = 1'b1;
            addr_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      phase_q <= 1'b0;
      disp_q  <= '0;
      sr_q    <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
      prow_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
      sr_q    <= sr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
      prow_q  <= prow_d;
      done_q  <= done_d;
    end
  end

  assign frame_row_rd   = rd_q;
  assign frame_row_addr = addr_q;
  assign panel_data     = data_q;
  assign panel_sclk     = sclk_q;
  assign panel_latch    = latch_q;
  assign panel_oe_n     = oe_n_q;
  assign panel_row      = prow_q;
  assign frame_done     = done_q;

endmodule
